// File: rtl/micro1_pin_host_if.sv
// Local command/response port of the micro1 pin host.
// Latency: n/a (signal bundle only).
// Backpressure: cmd side uses valid/ready, rsp side is a one-cycle pulse with no backpressure.
interface micro1_pin_host_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;

    // master = command issuer, slave = the pin host
    modport master (
        output cmd_valid, cmd_write, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_timeout
    );
endinterface

// File: rtl/micro1_pin_host.sv
// Drives one byte read/write per command over the micro1 4-phase REQ/ACK pin link.
// Latency: 1 setup cycle + ACK wait + release wait + 1 response cycle; each wait bounded by TIMEOUT_CYCLES.
// Backpressure: cmd_ready low from accept until the cycle after the response; offers while busy are dropped.
module micro1_pin_host #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    micro1_pin_host_if.slave        bus,
    output logic                    busy,
    output logic [7:0]              pin_ui,
    output logic [7:0]              pin_uio_drv,
    input  logic [7:0]              pin_uo,
    input  logic [7:0]              pin_uio,
    input  logic [7:0]              pin_uio_oe
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ_HI,
        S_REQ_LO,
        S_RESP
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   timeout_nxt;

    logic                   ack_raw;
    logic                   ack_s;
    logic [SYNC_STAGES-1:0] ack_sync;

    logic [TW-1:0]          timer;
    logic                   timer_done;

    logic                   cmd_ready_q;
    logic                   accept;
    logic                   is_read_q;
    logic                   timeout_q;
    logic [7:0]             ui_q;
    logic [7:0]             rd_data_q;
    logic                   req_q;
    logic                   rd_q;
    logic                   unused_pins;

    // A device that is not driving uio[1] cannot be acknowledging.
    assign ack_raw = pin_uio[1] & pin_uio_oe[1];
    assign unused_pins = ^{pin_uio[7:2], pin_uio[0], pin_uio_oe[7:2], pin_uio_oe[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
        end else begin
            ack_sync[0] <= ack_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                ack_sync[i] <= ack_sync[i-1];
            end
        end
    end

    assign ack_s      = ack_sync[SYNC_STAGES-1];
    assign accept     = bus.cmd_valid & cmd_ready_q;
    assign timer_done = (timer == TIMER_LAST);

    always_comb begin
        state_nxt   = state;
        timeout_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                state_nxt = S_REQ_HI;
            end
            S_REQ_HI: begin
                if (ack_s) begin
                    state_nxt = S_REQ_LO;
                end else if (timer_done) begin
                    state_nxt   = S_RESP;
                    timeout_nxt = 1'b1;
                end
            end
            S_REQ_LO: begin
                if (!ack_s) begin
                    state_nxt = S_RESP;
                end else if (timer_done) begin
                    state_nxt   = S_RESP;
                    timeout_nxt = 1'b1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Every pin and handshake output is a flop so reset clears the link at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd_ready_q <= 1'b0;
            req_q       <= 1'b0;
            rd_q        <= 1'b0;
            ui_q        <= 8'h00;
            is_read_q   <= 1'b0;
            timeout_q   <= 1'b0;
            rd_data_q   <= 8'h00;
            timer       <= '0;
        end else begin
            state       <= state_nxt;
            cmd_ready_q <= (state_nxt == S_IDLE);
            req_q       <= (state_nxt == S_REQ_HI);

            if (state_nxt != state) begin
                timer <= '0;
            end else if (state == S_REQ_HI || state == S_REQ_LO) begin
                timer <= timer + TW'(1);
            end

            if (accept) begin
                is_read_q <= ~bus.cmd_write;
                rd_q      <= ~bus.cmd_write;
                ui_q      <= bus.cmd_write ? bus.cmd_data : 8'h00;
                timeout_q <= 1'b0;
            end else if (state_nxt == S_RESP) begin
                rd_q      <= 1'b0;
                ui_q      <= 8'h00;
                timeout_q <= timeout_nxt;
            end

            if (state == S_REQ_HI && ack_s && is_read_q) begin
                rd_data_q <= pin_uo;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = (state == S_RESP);
    assign bus.rsp_timeout = (state == S_RESP) & timeout_q;
    assign bus.rsp_data    = ((state == S_RESP) && is_read_q && !timeout_q) ? rd_data_q : 8'h00;
    assign busy            = (state != S_IDLE);
    assign pin_ui          = ui_q;
    assign pin_uio_drv     = {5'b00000, rd_q, 1'b0, req_q};

endmodule

// File: tb/tb_micro1_pin_host.sv
// Random and directed commands against a device model; responses checked from a scoreboard queue.
module tb_micro1_pin_host;
    localparam int TO = 8;

    typedef enum int {M_NORMAL, M_NEVER, M_OE_LOW, M_STUCK} mode_t;
    typedef struct packed { logic to; logic [7:0] d; } rsp_t;
    typedef struct packed { logic rd; logic [7:0] ui; } cmd_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       busy;
    logic [7:0] pin_ui, pin_uio_drv;
    logic [7:0] pin_uo = 8'h00, pin_uio = 8'h00, pin_uio_oe = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;
    int rsp_cnt = 0;

    rsp_t       exp_rsp_q[$];
    cmd_t       exp_cmd_q[$];
    logic [7:0] dev_q[$];
    mode_t      mode = M_NORMAL;

    micro1_pin_host_if bus();

    micro1_pin_host #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .busy        (busy),
        .pin_ui      (pin_ui),
        .pin_uio_drv (pin_uio_drv),
        .pin_uo      (pin_uo),
        .pin_uio     (pin_uio),
        .pin_uio_oe  (pin_uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome derived from the link rules: a silent/masked/stuck device times out with data 0.
    task automatic issue(input bit wr, input logic [7:0] d, input logic [7:0] rv, input bit hold);
        bit   got = 1'b0;
        rsp_t r;
        cmd_t c;
        c.rd = !wr;
        c.ui = wr ? d : 8'h00;
        r.to = (mode != M_NORMAL);
        r.d  = (!wr && mode == M_NORMAL) ? rv : 8'h00;
        exp_rsp_q.push_back(r);
        exp_cmd_q.push_back(c);
        if (!wr && mode == M_NORMAL) dev_q.push_back(rv);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_data  = d;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) got = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!hold) begin
            bus.cmd_valid = 1'b0;
            bus.cmd_write = 1'($urandom);
            bus.cmd_data  = 8'($urandom);
        end
        chk("cmd_accept", 32'(got), 32'd1);
        if (!got) begin
            void'(exp_rsp_q.pop_back());
            void'(exp_cmd_q.pop_back());
            if (!wr && mode == M_NORMAL) void'(dev_q.pop_back());
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_rsp_q.size() == 0 && !busy) done = 1'b1;
        end
        chk("idle_reached", 32'(done), 32'd1);
        if (!done) exp_rsp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_normal();
        mode = M_NORMAL;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Device model: acknowledges REQ after a random delay, releases after REQ drops.
    logic       ack_q;
    logic       prev_req;
    int         dly;
    int         hi_cnt;
    cmd_t       cur;
    logic [7:0] cur_val;

    initial begin
        ack_q = 1'b0; prev_req = 1'b0; dly = 0; hi_cnt = 0; cur = '0; cur_val = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ack_q = 1'b0; prev_req = 1'b0; hi_cnt = 0;
            end else begin
                if (pin_uio_drv[0] && !prev_req) begin
                    if (exp_cmd_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL dev_unexpected_req: rd=%0b ui=%02h with no command pending", pin_uio_drv[2], pin_ui);
                        cur = {pin_uio_drv[2], pin_ui};
                    end else begin
                        cur = exp_cmd_q.pop_front();
                        chk("dev_cmd_seen", 32'({pin_uio_drv[2], pin_ui}), 32'(cur));
                    end
                    if (cur.rd && mode == M_NORMAL && dev_q.size() > 0) cur_val = dev_q.pop_front();
                    else cur_val = 8'($urandom);
                    dly = $urandom_range(0, 2);
                    hi_cnt = 0;
                end
                if (pin_uio_drv[0]) begin
                    hi_cnt++;
                    chk("dev_pins_held", 32'({pin_uio_drv[2], pin_ui}), 32'(cur));
                    if (!ack_q && mode != M_NEVER) begin
                        if (dly == 0) begin
                            ack_q  = 1'b1;
                            pin_uo = cur_val;
                        end else dly--;
                    end
                end else begin
                    if (prev_req) begin
                        if (mode == M_NEVER || mode == M_OE_LOW) chk("req_hi_timeout_len", 32'(hi_cnt), 32'(TO));
                        else chk("req_hi_len_range", 32'(hi_cnt >= 3 && hi_cnt <= TO), 32'd1);
                        dly = $urandom_range(0, 2);
                    end
                    if (ack_q && mode != M_STUCK) begin
                        if (dly == 0) ack_q = 1'b0;
                        else dly--;
                    end
                end
                prev_req = pin_uio_drv[0];
            end
            pin_uio    = {6'($urandom), ack_q, 1'($urandom)};
            pin_uio_oe = {6'($urandom), (mode != M_OE_LOW), 1'($urandom)};
        end
    end

    // Response monitor and per-cycle output invariants.
    rsp_t mon_e;
    logic prev_rsp = 1'b0;

    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            rsp_cnt++;
            if (exp_rsp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rsp_unexpected: data=%02h timeout=%0b with nothing expected", bus.rsp_data, bus.rsp_timeout);
            end else begin
                mon_e = exp_rsp_q.pop_front();
                chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.d));
                chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(mon_e.to));
            end
            chk("resp_pins_idle", 32'({pin_ui, pin_uio_drv}), 32'd0);
        end else begin
            chk("rsp_quiet", 32'({bus.rsp_data, bus.rsp_timeout}), 32'd0);
        end
        chk("uio_fixed_zero", 32'({pin_uio_drv[7:3], pin_uio_drv[1]}), 32'd0);
        if (busy) chk("ready_while_busy", 32'(bus.cmd_ready), 32'd0);
        if (prev_rsp && !rst) chk("ready_after_resp", 32'({bus.cmd_ready, busy}), 32'b10);
        prev_rsp = bus.rsp_valid;
    end

    initial begin
        #200000;
        n_tests++; n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_data  = 8'h00;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_timeout, bus.rsp_data, busy, pin_ui, pin_uio_drv}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_init", 32'(bus.cmd_ready), 32'd1);

        issue(1'b1, 8'hA5, 8'h00, 1'b0);
        wait_idle();
        issue(1'b0, 8'h00, 8'h3C, 1'b0);
        wait_idle();

        mode = M_NEVER;
        issue(1'b1, 8'h77, 8'h00, 1'b0);
        wait_idle();
        issue(1'b0, 8'h00, 8'h99, 1'b0);
        wait_idle();
        settle_normal();

        mode = M_OE_LOW;
        issue(1'b0, 8'h00, 8'h42, 1'b0);
        wait_idle();
        settle_normal();

        mode = M_STUCK;
        issue(1'b0, 8'h00, 8'h55, 1'b0);
        wait_idle();
        settle_normal();

        // Reset in the middle of REQ_HI: command is lost, pins clear immediately.
        issue(1'b1, 8'h5A, 8'h00, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(posedge clk);
                #1;
                if (pin_uio_drv[0]) seen = 1'b1;
            end
            chk("req_seen_before_rst", 32'(seen), 32'd1);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_pins_clear", 32'({pin_ui, pin_uio_drv}), 32'd0);
        chk("rst_busy_ready", 32'({busy, bus.cmd_ready}), 32'd0);
        if (exp_rsp_q.size() > 0) void'(exp_rsp_q.pop_back());
        exp_cmd_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
        settle_normal();
        issue(1'b1, 8'hC3, 8'h00, 1'b0);
        wait_idle();

        // cmd_valid held high across three reads.
        begin
            int c0;
            c0 = rsp_cnt;
            issue(1'b0, 8'hE1, 8'h01, 1'b1);
            issue(1'b0, 8'hE2, 8'h02, 1'b1);
            issue(1'b0, 8'hE3, 8'h03, 1'b0);
            wait_idle();
            chk("b2b_rsp_count", 32'(rsp_cnt - c0), 32'd3);
        end

        for (int k = 0; k < 40; k++) begin
            bit wr;
            bit hold;
            wr   = 1'($urandom_range(0, 1));
            hold = (k < 39) && ($urandom_range(0, 3) == 0);
            issue(wr, 8'($urandom), 8'($urandom), hold);
            if (!hold) wait_idle();
        end

        wait_idle();
        chk("scoreboard_empty", 32'(exp_rsp_q.size() + exp_cmd_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
